// File: rtl/parser_rule_cfg_scheduler_if.sv
// Rule-write ingress and per-stage commit bus between the config front end,
// the scheduler and the parser stages.
interface parser_rule_cfg_scheduler_if #(
    parameter int NUM_STAGES = 4
);
    logic                  i_rule_wren;
    logic [31:0]           i_rule_addr;
    logic [31:0]           i_rule_wdata;
    logic [NUM_STAGES-1:0] i_stage_busy;
    logic [NUM_STAGES-1:0] o_stage_wren;
    logic [15:0]           o_stage_addr;
    logic [31:0]           o_stage_wdata;
    logic                  o_hold_req;
    logic                  o_cfg_pending;
    logic [15:0]           o_drop_cnt;
    logic                  o_overflow;

    modport master (
        output i_rule_wren, i_rule_addr, i_rule_wdata, i_stage_busy,
        input  o_stage_wren, o_stage_addr, o_stage_wdata, o_hold_req,
               o_cfg_pending, o_drop_cnt, o_overflow
    );

    modport slave (
        input  i_rule_wren, i_rule_addr, i_rule_wdata, i_stage_busy,
        output o_stage_wren, o_stage_addr, o_stage_wdata, o_hold_req,
               o_cfg_pending, o_drop_cnt, o_overflow
    );
endinterface

// File: rtl/parser_rule_cfg_scheduler.sv
// Buffers parser rule writes and commits each one to its stage only while that
// stage holds no PHV, requesting an upstream hold if the stage stays busy.
//
// state | meaning
// IDLE  | FIFO empty, nothing held
// LOAD  | head entry captured; validate stage index, clear wait timer
// WAIT  | waiting for the target stage to go idle; timer drives hold request
// WRITE | one-cycle strobe to the target stage; pops the next entry if present
module parser_rule_cfg_scheduler #(
    parameter int NUM_STAGES   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int WAIT_TIMEOUT = 64
) (
    input logic                        i_clk,
    input logic                        i_rst_n,
    parser_rule_cfg_scheduler_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, WRITE} state_t;

    typedef struct packed {
        logic [3:0]  stage;
        logic [15:0] offset;
        logic [31:0] data;
    } entry_t;

    entry_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    state_t                state;
    entry_t                held;
    logic [TMR_W-1:0]      timer;

    logic                  fifo_ne;
    logic                  push_ok;
    logic                  push_drop;
    logic                  pop;
    logic                  load_drop;
    logic                  goes_idle;
    logic [NUM_STAGES-1:0] stage_sel;
    logic [16:0]           drop_sum;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus.i_rule_addr[27:16];

    assign fifo_ne   = (count != '0);
    assign push_ok   = bus.i_rule_wren && (32'(count) < FIFO_DEPTH);
    assign push_drop = bus.i_rule_wren && !push_ok;
    // WRITE pops directly into LOAD so back-to-back commits take three cycles.
    assign pop       = fifo_ne && ((state == IDLE) || (state == WRITE));
    assign load_drop = (state == LOAD) && (32'(held.stage) >= NUM_STAGES);
    assign stage_sel = NUM_STAGES'(1) << held.stage;
    assign goes_idle = (((state == IDLE) || (state == WRITE)) && !fifo_ne) || load_drop;
    assign drop_sum  = {1'b0, bus.o_drop_cnt} + 17'(push_drop) + 17'(load_drop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{stage:  bus.i_rule_addr[31:28],
                             offset: bus.i_rule_addr[15:0],
                             data:   bus.i_rule_wdata};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            bus.o_drop_cnt    <= '0;
            bus.o_overflow    <= 1'b0;
            bus.o_cfg_pending <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            if (push_drop) begin
                bus.o_overflow <= 1'b1;
            end
            bus.o_drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            bus.o_cfg_pending <= (count_nxt != '0) || !goes_idle;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            held              <= '0;
            timer             <= '0;
            bus.o_stage_wren  <= '0;
            bus.o_stage_addr  <= '0;
            bus.o_stage_wdata <= '0;
            bus.o_hold_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_ne) begin
                        held  <= mem[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_drop) begin
                        state <= IDLE;
                    end else begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if ((bus.i_stage_busy & stage_sel) == '0) begin
                        bus.o_stage_wren  <= stage_sel;
                        bus.o_stage_addr  <= held.offset;
                        bus.o_stage_wdata <= held.data;
                        state             <= WRITE;
                    end else begin
                        if (32'(timer) < WAIT_TIMEOUT - 1) begin
                            timer <= timer + TMR_W'(1);
                        end
                        if (32'(timer) == WAIT_TIMEOUT - 1) begin
                            bus.o_hold_req <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    bus.o_stage_wren  <= '0;
                    bus.o_stage_addr  <= '0;
                    bus.o_stage_wdata <= '0;
                    bus.o_hold_req    <= 1'b0;
                    if (fifo_ne) begin
                        held  <= mem[rd_ptr];
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parser_rule_cfg_scheduler.sv
// Scoreboard bench: stimulus queues expected stage commits, a negedge monitor
// pops and compares every strobe; drop/overflow/hold checked against a model.
module tb_parser_rule_cfg_scheduler;
    localparam int NS = 4;

    typedef struct packed {
        logic [3:0]  stage;
        logic [15:0] off;
        logic [31:0] data;
    } wr_t;

    logic i_clk;
    logic i_rst_n;

    parser_rule_cfg_scheduler_if #(.NUM_STAGES(NS)) bus ();

    parser_rule_cfg_scheduler #(
        .NUM_STAGES(NS), .FIFO_DEPTH(16), .WAIT_TIMEOUT(64)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    wr_t exp_q[$];
    int  strobe_cyc_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  exp_drop = 0;
    int  cyc = 0;
    int  last_strobe_cyc = 0;
    int  strobe_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge i_clk) begin : monitor
        wr_t e;
        logic [NS-1:0] oh;
        if (i_rst_n && bus.o_stage_wren != '0) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            strobe_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'(bus.o_stage_wren), 64'd0);
            end else begin
                e  = exp_q.pop_front();
                oh = NS'(1) << e.stage;
                check("strobe_sel", 64'(bus.o_stage_wren), 64'(oh));
                check("strobe_addr", 64'(bus.o_stage_addr), 64'(e.off));
                check("strobe_data", 64'(bus.o_stage_wdata), 64'(e.data));
            end
        end
    end

    task automatic push(input logic [31:0] addr, input logic [31:0] data, input bit accept);
        wr_t w;
        bus.i_rule_wren  = 1'b1;
        bus.i_rule_addr  = addr;
        bus.i_rule_wdata = data;
        if (!accept || int'(addr[31:28]) >= NS) begin
            exp_drop++;
        end else begin
            w.stage = addr[31:28];
            w.off   = addr[15:0];
            w.data  = data;
            exp_q.push_back(w);
        end
        @(negedge i_clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        bus.i_rule_wren = 1'b0;
        repeat (2) @(negedge i_clk);
        n = 0;
        while ((bus.o_cfg_pending || exp_q.size() != 0) && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check({name, "_pending"}, 64'(bus.o_cfg_pending), 64'd0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_wren"}, 64'(bus.o_stage_wren), 64'd0);
        check({name, "_addr"}, 64'(bus.o_stage_addr), 64'd0);
        check({name, "_wdata"}, 64'(bus.o_stage_wdata), 64'd0);
        check({name, "_hold"}, 64'(bus.o_hold_req), 64'd0);
        check({name, "_pending"}, 64'(bus.o_cfg_pending), 64'd0);
        check({name, "_drop"}, 64'(bus.o_drop_cnt), 64'd0);
        check({name, "_ovf"}, 64'(bus.o_overflow), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int base, cnt0, d, nb;
        logic h66, h67, h101, h102, hold_ok, max_hold;
        logic [3:0] st;

        i_rst_n          = 1'b1;
        bus.i_rule_wren  = 1'b0;
        bus.i_rule_addr  = '0;
        bus.i_rule_wdata = '0;
        bus.i_stage_busy = '0;
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_outputs_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // single write, idle stages: strobe exactly 4 cycles after the push
        base = cyc;
        cnt0 = strobe_cnt;
        push(32'h1000_0005, 32'hDEAD_BEEF, 1'b1);
        wait_drain("t1");
        check("t1_latency", 64'(last_strobe_cyc - base), 64'd4);
        check("t1_one_strobe", 64'(strobe_cnt - cnt0), 64'd1);

        // back-to-back writes commit every 3 cycles
        strobe_cyc_q.delete();
        push(32'h0000_0011, $urandom, 1'b1);
        push(32'h1000_0022, $urandom, 1'b1);
        push(32'h3000_0033, $urandom, 1'b1);
        wait_drain("thru");
        check("thru_count", 64'(strobe_cyc_q.size()), 64'd3);
        if (strobe_cyc_q.size() == 3) begin
            check("thru_gap0", 64'(strobe_cyc_q[1] - strobe_cyc_q[0]), 64'd3);
            check("thru_gap1", 64'(strobe_cyc_q[2] - strobe_cyc_q[1]), 64'd3);
        end

        // stage 2 busy for 10 cycles: strobe the cycle after busy drops, no hold
        bus.i_stage_busy = 4'b0100;
        base     = cyc;
        cnt0     = strobe_cnt;
        max_hold = 1'b0;
        push(32'h2ABC_0010, $urandom, 1'b1);
        bus.i_rule_wren = 1'b0;
        while (cyc - base < 10) begin
            max_hold |= bus.o_hold_req;
            @(negedge i_clk);
        end
        bus.i_stage_busy = '0;
        wait_drain("t2");
        check("t2_latency", 64'(last_strobe_cyc - base), 64'd11);
        check("t2_one_strobe", 64'(strobe_cnt - cnt0), 64'd1);
        check("t2_no_hold", 64'(max_hold), 64'd0);

        // stage 3 busy 100 cycles: hold rises 64 cycles after WAIT entry
        bus.i_stage_busy = 4'b1000;
        base    = cyc;
        hold_ok = 1'b1;
        h66 = 1'bx; h67 = 1'bx; h101 = 1'bx; h102 = 1'bx;
        push(32'h3000_0100, $urandom, 1'b1);
        bus.i_rule_wren = 1'b0;
        while (cyc - base <= 102) begin
            d = cyc - base;
            if (d == 66)  h66  = bus.o_hold_req;
            if (d == 67)  h67  = bus.o_hold_req;
            if (d == 101) h101 = bus.o_hold_req;
            if (d == 102) h102 = bus.o_hold_req;
            if (d >= 67 && d <= 101 && bus.o_hold_req !== 1'b1) hold_ok = 1'b0;
            if (d == 100) bus.i_stage_busy = '0;
            @(negedge i_clk);
        end
        wait_drain("t3");
        check("t3_hold_before", 64'(h66), 64'd0);
        check("t3_hold_rise", 64'(h67), 64'd1);
        check("t3_hold_steady", 64'(hold_ok), 64'd1);
        check("t3_hold_in_write", 64'(h101), 64'd1);
        check("t3_hold_after", 64'(h102), 64'd0);
        check("t3_latency", 64'(last_strobe_cyc - base), 64'd101);

        // overflow: stage 0 held busy, 20 back-to-back, 17 retained
        bus.i_stage_busy = 4'b0001;
        cnt0 = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            push({4'h0, 12'($urandom), 16'(i)}, $urandom, i < 17);
        end
        bus.i_rule_wren = 1'b0;
        repeat (2) @(negedge i_clk);
        check("t4_overflow", 64'(bus.o_overflow), 64'd1);
        check("t4_drop_cnt", 64'(bus.o_drop_cnt), 64'(exp_drop));
        check("t4_no_strobe_while_busy", 64'(strobe_cnt - cnt0), 64'd0);
        bus.i_stage_busy = '0;
        wait_drain("t4");
        check("t4_commits", 64'(strobe_cnt - cnt0), 64'd17);

        // invalid stage index is discarded, next entry proceeds
        cnt0 = strobe_cnt;
        push(32'h7000_0001, $urandom, 1'b1);
        push(32'h0000_0002, $urandom, 1'b1);
        wait_drain("t5");
        check("t5_drop_cnt", 64'(bus.o_drop_cnt), 64'(exp_drop));
        check("t5_commits", 64'(strobe_cnt - cnt0), 64'd1);

        // randomized bursts with random stage busy and some invalid stages
        for (int b = 0; b < 30; b++) begin
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                bus.i_stage_busy = NS'($urandom & $urandom);
                st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                                 : 4'($urandom_range(0, 3));
                push({st, 12'($urandom), 16'($urandom)}, $urandom, 1'b1);
                bus.i_rule_wren = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    bus.i_stage_busy = NS'($urandom & $urandom);
                    @(negedge i_clk);
                end
            end
            bus.i_stage_busy = '0;
            wait_drain("rand");
        end
        check("rand_drop_cnt", 64'(bus.o_drop_cnt), 64'(exp_drop));
        check("rand_overflow_sticky", 64'(bus.o_overflow), 64'd1);

        // reset during WAIT with 5 entries queued behind a busy stage
        bus.i_stage_busy = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            push({4'h1, 12'h000, 16'(i)}, $urandom, 1'b1);
        end
        bus.i_rule_wren = 1'b0;
        repeat (4) @(negedge i_clk);
        check("rst_pending_before", 64'(bus.o_cfg_pending), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        exp_q.delete();
        exp_drop = 0;
        cnt0 = strobe_cnt;
        repeat (2) @(negedge i_clk);
        bus.i_stage_busy = '0;
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check("rst_no_strobe", 64'(strobe_cnt - cnt0), 64'd0);
        check("rst_pending_after", 64'(bus.o_cfg_pending), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
